// File: rtl/pe_pkg.sv
// Shared PE-array constants and the packed matrix/column element layout.
package pe_pkg;

   localparam int unsigned DW    = 16;
   localparam int unsigned ROWS  = 16;
   localparam int unsigned COLS  = 10;
   localparam int unsigned COL_W = ROWS * DW;
   localparam int unsigned MAT_W = ROWS * COLS * DW;
   localparam int unsigned CNT_W = $clog2(COLS);

   typedef enum logic {
      ST_COLLECT = 1'b0,
      ST_FULL    = 1'b1
   } pack_state_e;

   // LSB of element (r,c) in the row-major packed matrix; (0,0) sits at the MSB end.
   function automatic int unsigned elem_lsb(input int unsigned r, input int unsigned c);
      return MAT_W - (r * COLS + c + 1) * DW;
   endfunction

   // LSB of row element r in a packed column vector.
   function automatic int unsigned col_lsb(input int unsigned r);
      return COL_W - (r + 1) * DW;
   endfunction

endpackage

// File: rtl/matrix_pack_10_col.sv
// Gathers COLS column vectors, one per beat, into a row-major packed matrix and
// hands it to the storage stage over a valid/ready handshake.
module matrix_pack_10_col
   import pe_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [COL_W-1:0] col_data,
   input  logic             col_valid,
   input  logic             col_last,
   output logic             col_ready,
   output logic [MAT_W-1:0] Matrix,
   output logic             mat_valid,
   input  logic             mat_ready,
   output logic             finish,
   output logic             col_err
);

   pack_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mat_valid_q, mat_valid_d;
   logic             finish_q, finish_d;
   logic             col_err_q, col_err_d;

   logic col_acc;
   logic mat_hs;
   logic last_col;

   assign col_ready = en && ((state_q == ST_COLLECT) || ((state_q == ST_FULL) && mat_ready));
   assign col_acc   = col_valid && col_ready;
   assign mat_hs    = mat_valid_q && mat_ready && en;
   assign last_col  = (cnt_q == CNT_W'(COLS - 1));

   assign mat_valid = mat_valid_q;
   assign col_err   = col_err_q;
   // finish is suppressed while stalled or in reset; a pending pulse waits for en.
   assign finish    = finish_q && en && rst_n;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_COLLECT;
         cnt_q       <= '0;
         mat_valid_q <= 1'b0;
         finish_q    <= 1'b0;
         col_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mat_valid_q <= mat_valid_d;
         finish_q    <= finish_d;
         col_err_q   <= col_err_d;
      end
   end

   // Next state: a handshake in FULL and an accept of the next column 0 may coincide.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mat_valid_d = mat_valid_q;
      finish_d    = en ? 1'b0 : finish_q;
      col_err_d   = col_err_q;

      if (mat_hs) begin
         state_d     = ST_COLLECT;
         mat_valid_d = 1'b0;
      end

      if (col_acc) begin
         if (col_last != last_col) begin
            col_err_d = 1'b1;
         end
         if (last_col) begin
            cnt_d       = '0;
            state_d     = ST_FULL;
            mat_valid_d = 1'b1;
            finish_d    = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Column scatter: each row keeps its own COLS elements, written at index cnt_q.
   for (genvar r = 0; r < ROWS; r++) begin : g_row
      logic [COLS*DW-1:0] row_q;

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            row_q <= '0;
         end else if (col_acc) begin
            for (int c = 0; c < COLS; c++) begin
               if (cnt_q == CNT_W'(c)) begin
                  row_q[elem_lsb(r, c) - elem_lsb(r, COLS - 1) +: DW] <= col_data[col_lsb(r) +: DW];
               end
            end
         end
      end

      assign Matrix[elem_lsb(r, COLS - 1) +: COLS*DW] = row_q;
   end

endmodule

// File: tb/tb_matrix_pack_10_col.sv
// Directed scenarios plus randomized traffic against a behavioural matrix model.
module tb_matrix_pack_10_col;
   import pe_pkg::*;

   logic             clk = 1'b0;
   logic             rst_n, en, col_valid, col_last, mat_ready;
   logic [COL_W-1:0] col_data;
   logic             col_ready, mat_valid, finish, col_err;
   logic [MAT_W-1:0] Matrix;

   matrix_pack_10_col dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .col_data  (col_data),
      .col_valid (col_valid),
      .col_last  (col_last),
      .col_ready (col_ready),
      .Matrix    (Matrix),
      .mat_valid (mat_valid),
      .mat_ready (mat_ready),
      .finish    (finish),
      .col_err   (col_err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: matrix contents, columns gathered so far, full flag, sticky error.
   logic [DW-1:0] m_mat [ROWS][COLS];
   int            m_idx;
   bit            m_full, m_err, m_fin, m_known;

   logic [MAT_W-1:0] mat_snap;
   logic             mv_snap, fin_snap, rdy_snap, err_snap;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [MAT_W-1:0] model_matrix();
      logic [MAT_W-1:0] v;
      v = '0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            v[MAT_W-1-(r*COLS+c)*DW -: DW] = m_mat[r][c];
      return v;
   endfunction

   function automatic logic [COL_W-1:0] mk_col(input logic [15:0] base, input int c);
      logic [COL_W-1:0] v;
      for (int r = 0; r < ROWS; r++)
         v[COL_W-1-r*DW -: DW] = base | 16'(r << 8) | 16'(c);
      return v;
   endfunction

   task automatic check_mat_snap(input string tag, input logic [MAT_W-1:0] exp);
      for (int k = 0; k < MAT_W/256; k++)
         check($sformatf("%s[%0d]", tag, k), mat_snap[MAT_W-1-k*256 -: 256], exp[MAT_W-1-k*256 -: 256]);
   endtask

   // One clock: drive, compare at the falling edge, advance the model at the rising edge.
   task automatic cycle(input bit e, input bit rn, input bit v, input bit l,
                        input logic [COL_W-1:0] d, input bit mr);
      bit exp_rdy, acc, fin_n;
      en = e; rst_n = rn; col_valid = v; col_last = l; col_data = d; mat_ready = mr;
      @(negedge clk);
      mat_snap = Matrix; mv_snap = mat_valid; fin_snap = finish;
      rdy_snap = col_ready; err_snap = col_err;
      exp_rdy = e && (!m_full || mr);
      if (m_known) begin
         check("col_ready", 256'(col_ready), 256'(exp_rdy));
         check("mat_valid", 256'(mat_valid), 256'(m_full));
         check("finish",    256'(finish),    256'(m_fin && e && rn));
         check("col_err",   256'(col_err),   256'(m_err));
         if (m_full) check_mat_snap("matrix", model_matrix());
      end
      if (!rn) begin
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) m_mat[r][c] = '0;
         m_idx = 0; m_full = 0; m_err = 0; m_fin = 0; m_known = 1;
      end else if (m_known && e) begin
         acc   = v && exp_rdy;
         fin_n = 0;
         if (m_full && mr) m_full = 0;
         if (acc) begin
            for (int r = 0; r < ROWS; r++) m_mat[r][m_idx] = d[COL_W-1-r*DW -: DW];
            if ((m_idx == COLS-1) != l) m_err = 1;
            m_idx++;
            if (m_idx == COLS) begin
               m_idx = 0; m_full = 1; fin_n = 1;
            end
         end
         m_fin = fin_n;
      end
      @(posedge clk); #1;
   endtask

   task automatic fill(input logic [15:0] base, input bit mr, input int err_beat);
      for (int c = 0; c < COLS; c++)
         cycle(1, 1, 1, (c == COLS-1) || (c == err_beat), mk_col(base, c), mr);
   endtask

   task automatic idle(input bit mr);
      cycle(1, 1, 0, 0, '0, mr);
   endtask

   initial begin
      logic [COL_W-1:0] rd;
      bit re, rrn, rv, rl, rmr;
      m_known = 0; m_full = 0; m_err = 0; m_fin = 0; m_idx = 0;
      rst_n = 0; en = 0; col_valid = 0; col_last = 0; col_data = '0; mat_ready = 0;
      @(posedge clk); #1;
      cycle(0, 0, 0, 0, '0, 0);
      cycle(1, 0, 0, 0, '0, 0);

      // reset state
      idle(0);
      check_mat_snap("rst_matrix", '0);
      check("rst_mat_valid", 256'(mv_snap), 256'(0));

      // basic fill
      fill(16'h0000, 1, -1);
      idle(1);
      check("basic_valid",  256'(mv_snap), 256'(1));
      check("basic_finish", 256'(fin_snap), 256'(1));
      check("basic_e00", 256'(mat_snap[2559:2544]), 256'(16'h0000));
      check("basic_e01", 256'(mat_snap[2543:2528]), 256'(16'h0001));
      check("basic_e10", 256'(mat_snap[2399:2384]), 256'(16'h0100));
      check("basic_e159", 256'(mat_snap[15:0]), 256'(16'h0F09));
      check("basic_err", 256'(err_snap), 256'(0));
      idle(1);

      // backpressure
      fill(16'h0000, 0, -1);
      for (int i = 0; i < 20; i++) cycle(1, 1, 1, 0, mk_col(16'h4000, 0), 0);
      cycle(1, 1, 0, 0, '0, 1);
      idle(1);
      check("bp_valid_drop", 256'(mv_snap), 256'(0));
      check("bp_ready_back", 256'(rdy_snap), 256'(1));

      // overlap of handshake and next column 0
      fill(16'h0000, 1, -1);
      cycle(1, 1, 1, 0, mk_col(16'h8000, 0), 1);
      check("ovl_accept", 256'(rdy_snap), 256'(1));
      for (int c = 1; c < COLS; c++) cycle(1, 1, 1, c == COLS-1, mk_col(16'h8000, c), 1);
      idle(1);
      check("ovl_valid", 256'(mv_snap), 256'(1));
      check("ovl_e00",   256'(mat_snap[2559:2544]), 256'(16'h8000));
      check("ovl_e159",  256'(mat_snap[15:0]), 256'(16'h8F09));
      idle(1);

      // framing error on beat 4
      fill(16'h1000, 1, 4);
      idle(1);
      check("frm_err",   256'(err_snap), 256'(1));
      check("frm_valid", 256'(mv_snap), 256'(1));
      idle(1);

      // reset mid-collection
      for (int c = 0; c < 6; c++) cycle(1, 1, 1, 0, mk_col(16'h2000, c), 1);
      cycle(1, 0, 0, 0, '0, 1);
      idle(1);
      check_mat_snap("mid_rst_matrix", '0);
      check("mid_rst_valid", 256'(mv_snap), 256'(0));
      check("mid_rst_err",   256'(err_snap), 256'(0));
      fill(16'h3000, 1, -1);
      idle(1);
      check("post_rst_e00",  256'(mat_snap[2559:2544]), 256'(16'h3000));
      check("post_rst_e159", 256'(mat_snap[15:0]), 256'(16'h3F09));
      idle(1);

      // enable stall after beat 3
      for (int c = 0; c < 4; c++) cycle(1, 1, 1, 0, mk_col(16'h5000, c), 1);
      for (int i = 0; i < 5; i++) begin
         cycle(0, 1, 1, 0, mk_col(16'h5000, 4), 1);
         check("stall_ready", 256'(rdy_snap), 256'(0));
      end
      for (int c = 4; c < COLS; c++) cycle(1, 1, 1, c == COLS-1, mk_col(16'h5000, c), 1);
      idle(1);
      check("stall_valid", 256'(mv_snap), 256'(1));
      check("stall_e04",   256'(mat_snap[2495:2480]), 256'(16'h5004));
      check("stall_e159",  256'(mat_snap[15:0]), 256'(16'h5F09));
      idle(1);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         for (int w = 0; w < COL_W/32; w++) rd[w*32 +: 32] = $urandom;
         re  = ($urandom_range(0, 7) != 0);
         rrn = ($urandom_range(0, 99) != 0);
         rv  = ($urandom_range(0, 9) < 7);
         rmr = ($urandom_range(0, 2) != 0);
         rl  = (m_idx == COLS-1) ^ ($urandom_range(0, 24) == 0);
         cycle(re, rrn, rv, rl, rd, rmr);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/matrix_pack_10_col.md
Name: matrix_pack_10_col

Overview:
- Inverse of the row-to-PE distribution path. Collects the 10 per-PE result column vectors (16 elements each), arriving one per beat, into a 16x10 row-major packed matrix.
- Presents the packed matrix with a valid/ready handshake to the write-back/storage stage.
- Sits between the PE16 array outputs and the matrix buffer.

Parameters:
- DW, 16, element width in bits (signed).
- ROWS, 16, elements per column vector = matrix rows.
- COLS, 10, column vectors per matrix = matrix columns.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- en  in  1  block enable; when low, no handshakes complete and all state holds.
- col_data  in  ROWS*DW  one column vector; row r element at bits [ROWS*DW-1-r*DW -: DW].
- col_valid  in  1  col_data valid.
- col_last  in  1  producer marks the beat it intends as column COLS-1.
- col_ready  out  1  block accepts a column this cycle.
- Matrix  out  ROWS*COLS*DW  packed matrix; element (r,c) at bits [ROWS*COLS*DW-1-(r*COLS+c)*DW -: DW].
- mat_valid  out  1  Matrix complete and stable.
- mat_ready  in  1  consumer accepts Matrix.
- finish  out  1  one-cycle pulse on the first cycle mat_valid is high.
- col_err  out  1  sticky; set on col_last/counter mismatch.

Behaviour:
- Reset (rst_n=0 at a clock edge): Matrix=0, mat_valid=0, finish=0, col_err=0, col counter=0, state=COLLECT. Applies mid-collection; partial columns are discarded.
- States:
  - COLLECT: accepting columns 0..COLS-1.
  - FULL: matrix held for the consumer.
- col_ready = en && (state==COLLECT || (state==FULL && mat_ready)).
- Column accept = col_valid && col_ready.
  - Writes col_data into matrix column index = counter, scattering element r to position (r,counter).
  - Then counter increments.
- Accept with counter==COLS-1:
  - counter wraps to 0 and state goes to FULL.
  - mat_valid=1 and finish=1 on the next cycle (latency 1 clock after the 10th accept).
- col_last check:
  - col_last=1 on an accept with counter!=COLS-1 sets col_err; the column is still written and counting continues.
  - col_last=0 on the accept with counter==COLS-1 also sets col_err.
  - col_err clears only on reset.
- In FULL: Matrix and mat_valid are stable while mat_ready=0 (backpressure, unlimited duration).
- Matrix handshake = mat_valid && mat_ready && en.
  - mat_valid drops next cycle; state returns to COLLECT.
- Simultaneous matrix handshake and column accept in FULL:
  - The column is written as column 0 of the next matrix; counter becomes 1; state COLLECT.
  - No bubble is required between matrices.
- Columns 1..COLS-1 of the previous matrix are not cleared on reuse. Matrix content is only defined while mat_valid=1.
- finish is high for exactly one cycle per completed matrix and is never high during reset.
- en=0: col_ready=0, no matrix handshake, counter/state/Matrix/mat_valid hold; finish is forced 0 while en=0.
- Data is passed bit-exact; no arithmetic and no sign handling beyond preserving bits.

Decomposition:
- Shared package pe_pkg holds:
  - DW, ROWS, COLS constants.
  - Packed-width localparams: COL_W=ROWS*DW, MAT_W=ROWS*COLS*DW.
  - An element-offset function (r,c) -> bit position, used by both this block and the row-distribution block so both share one layout definition.
- No sub-module. Implement the column scatter as a generate loop over rows with a counter-indexed write.

Test Plan:
- Basic fill: 10 back-to-back beats, element(r,c)=16'h(r<<8|c), col_last on beat 9, mat_ready=1.
  - Expect mat_valid and finish 1 cycle after beat 9.
  - Matrix[2559:2544]=16'h0000, Matrix[2543:2528]=16'h0001, Matrix[2399:2384]=16'h0100, Matrix[15:0]=16'h0F09.
  - Matrix handshake completes that cycle; col_err=0.
- Backpressure: same fill with mat_ready=0 for 20 cycles.
  - Expect col_ready=0 and Matrix stable throughout, finish high only on the first cycle.
  - Then mat_ready=1 -> mat_valid=0 next cycle, col_ready=1.
- Overlap: hold col_valid=1 with second-matrix data (elements 16'h8000|r<<8|c) while mat_ready=1 in FULL.
  - Expect column 0 accepted in the same cycle as the matrix handshake.
  - Second matrix valid after 9 further beats with Matrix[2559:2544]=16'h8000.
- Framing error: col_last asserted on beat 4.
  - Expect col_err=1 from the next cycle, held through completion.
  - Matrix still completes after beat 9.
- Reset mid-operation: 6 beats, then rst_n=0 for 1 cycle, then 10 fresh beats.
  - Expect Matrix=0 and mat_valid=0 after reset.
  - Next matrix complete only after 10 new beats, containing only new data.
- Enable stall: en=0 for 5 cycles after beat 3 with col_valid=1.
  - Expect col_ready=0, no accepts, finish=0.
  - Resume completes after 6 more beats with correct column ordering.
